// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side controller: default word width,
// skid-buffer depth and the controller state encoding.
package fifo_reader_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OCC_MAX   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry register skid buffer. Words are written at the tail and read from
// the head. Entry 0 is always the head, so head_o needs no read multiplexer.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  // Next contents of the two entries and the fill level.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({wr_en_i, rd_en_i})
      2'b10: begin
        if (occ_q == 2'd0) head_d = wr_data_i;
        else               tail_d = wr_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Land and leave in the same cycle: occupancy is unchanged and the
        // head advances. With one word held the new word becomes the head.
        if (occ_q == 2'd1) begin
          head_d = wr_data_i;
        end else begin
          head_d = tail_q;
          tail_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the two entries are ordinary flops, not a RAM, and they are reset
    // so that out_data reads zero after reset rather than stale data.
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the values from before the edge.
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for a push/pop FIFO with one cycle of read latency.
// Issues pops while enabled, the FIFO is non-empty and the skid buffer has
// room, and presents words downstream on a valid/ready handshake.
// Optional build macro FIFO_READER_CNT_EN: when defined, word_count counts
// accepted transfers (wrapping); otherwise word_count is tied to zero.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [15:0]      word_count
);

  state_t     state_q, state_d;
  logic       pend_q;
  logic [1:0] occ;
  logic       xfer;
  logic [2:0] fill;
  logic [2:0] limit;

  fifo_reader_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (pend_q),
    .wr_data_i (fifo_data),
    .rd_en_i   (xfer),
    .head_o    (out_data),
    .occ_o     (occ)
  );

  assign out_valid = (occ != 2'd0);
  assign xfer      = out_valid & out_ready;

  // Pop only if the word, once it lands, still fits after this cycle's
  // transfer: occ + pend - xfer < OCC_MAX, rearranged to avoid underflow.
  // out_ready feeds fifo_pop combinationally to sustain one word per cycle.
  // Reset gates the pop so none is issued while reset is held.
  assign fill     = {1'b0, occ} + {2'b00, pend_q};
  assign limit    = 3'(OCC_MAX) + {2'b00, xfer};
  assign fifo_pop = ~reset & enable & ~fifo_empty & (fill < limit);

  // A pop this cycle means its data lands in the skid next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= fifo_pop;
  end

  // Controller state: tracks whether the reader is active or draining.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = STOP;
      STOP: begin
        if (enable)                              state_d = RUN;
        else if ((occ == 2'd0) && !pend_q)       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign busy = (state_q != IDLE);

`ifdef FIFO_READER_CNT_EN
  logic [15:0] count_q;

  // Accepted-transfer counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count_q <= 16'd0;
    else if (xfer) count_q <= count_q + 16'd1;
  end

  assign word_count = count_q;
`else
  assign word_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed testbench for fifo_reader. A small behavioural FIFO (queue with one
// cycle read latency) drives the read side; every expectation is hand-derived.
// Between pops the FIFO data bus carries a poison value so early or late
// sampling by the reader shows up as wrong data.
module tb_fifo_reader;

  localparam int         WIDTH  = 4;
  localparam logic [3:0] POISON = 4'hE;
`ifdef FIFO_READER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [15:0]      word_count;

  logic [WIDTH-1:0] fq[$];
  int vectors = 0;
  int miscompares = 0;

  fifo_reader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample the pop decision before the edge, model the FIFO's
  // one-cycle read latency after it, and return just after the falling edge.
  task automatic tick();
    logic pop_s;
    #1;
    pop_s = fifo_pop;
    @(posedge clk);
    #1;
    if (pop_s && fq.size() > 0) fifo_data = fq.pop_front();
    else                        fifo_data = POISON;
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] cnt(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction

  initial begin
    int rd_idx;
    int order_errs;

    reset      = 1'b1;
    enable     = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = POISON;
    out_ready  = 1'b0;
    @(negedge clk);
    #1;

    // Reset state.
    check("rst_pop",   {15'd0, fifo_pop},  16'd0);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_data",  {12'd0, out_data},  16'd0);
    check("rst_busy",  {15'd0, busy},      16'd0);
    check("rst_count", word_count,         16'd0);
    reset = 1'b0;
    tick();

    // 1: stream 3,5,9 with the consumer always ready.
    push(4'd3); push(4'd5); push(4'd9);
    enable = 1'b1; out_ready = 1'b1;
    #1;
    check("t1_pop_c0", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t1_pop_c1",   {15'd0, fifo_pop},  16'd1);
    check("t1_busy_c1",  {15'd0, busy},      16'd1);
    check("t1_valid_c1", {15'd0, out_valid}, 16'd0);
    tick();
    check("t1_pop_c2",   {15'd0, fifo_pop},  16'd1);
    check("t1_valid_c2", {15'd0, out_valid}, 16'd1);
    check("t1_data_c2",  {12'd0, out_data},  16'd3);
    tick();
    check("t1_pop_c3",  {15'd0, fifo_pop}, 16'd0);
    check("t1_data_c3", {12'd0, out_data}, 16'd5);
    tick();
    check("t1_data_c4", {12'd0, out_data}, 16'd9);
    tick();
    check("t1_valid_c5", {15'd0, out_valid}, 16'd0);
    check("t1_count",    word_count,         cnt(3));

    // 2: consumer stalled with 4 words queued, then released.
    out_ready = 1'b0;
    push(4'd1); push(4'd2); push(4'd4); push(4'd6);
    #1;
    check("t2_pop_c0", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t2_pop_c1", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t2_pop_c2",  {15'd0, fifo_pop}, 16'd0);
    check("t2_data_c2", {12'd0, out_data}, 16'd1);
    tick();
    check("t2_pop_c3",   {15'd0, fifo_pop},  16'd0);
    check("t2_valid_c3", {15'd0, out_valid}, 16'd1);
    check("t2_data_c3",  {12'd0, out_data},  16'd1);
    tick();
    check("t2_data_c4", {12'd0, out_data}, 16'd1);
    out_ready = 1'b1;
    #1;
    check("t2_pop_c4", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t2_data_c5", {12'd0, out_data}, 16'd2);
    tick();
    check("t2_data_c6", {12'd0, out_data}, 16'd4);
    tick();
    check("t2_data_c7", {12'd0, out_data}, 16'd6);
    tick();
    check("t2_valid_c8", {15'd0, out_valid}, 16'd0);
    check("t2_count",    word_count,         cnt(7));

    // 3: FIFO empty for several cycles, then a single word A.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_pop_empty%0d", i),   {15'd0, fifo_pop},  16'd0);
      check($sformatf("t3_valid_empty%0d", i), {15'd0, out_valid}, 16'd0);
      tick();
    end
    push(4'hA);
    #1;
    check("t3_pop_c0", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t3_pop_c1",   {15'd0, fifo_pop},  16'd0);
    check("t3_valid_c1", {15'd0, out_valid}, 16'd0);
    tick();
    check("t3_valid_c2", {15'd0, out_valid}, 16'd1);
    check("t3_data_c2",  {12'd0, out_data},  16'hA);
    tick();
    check("t3_valid_c3", {15'd0, out_valid}, 16'd0);
    check("t3_count",    word_count,         cnt(8));

    // 4: enable drops after two pops; the skid drains, then back to idle.
    out_ready = 1'b0;
    push(4'd7); push(4'd8); push(4'd3);
    #1;
    check("t4_pop_c0", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t4_pop_c1", {15'd0, fifo_pop}, 16'd1);
    tick();
    enable = 1'b0;
    #1;
    check("t4_pop_c2",  {15'd0, fifo_pop}, 16'd0);
    check("t4_busy_c2", {15'd0, busy},     16'd1);
    tick();
    check("t4_busy_c3", {15'd0, busy},     16'd1);
    check("t4_data_c3", {12'd0, out_data}, 16'd7);
    out_ready = 1'b1;
    #1;
    check("t4_pop_c3", {15'd0, fifo_pop}, 16'd0);
    tick();
    check("t4_data_c4", {12'd0, out_data}, 16'd8);
    check("t4_pop_c4",  {15'd0, fifo_pop}, 16'd0);
    check("t4_busy_c4", {15'd0, busy},     16'd1);
    tick();
    check("t4_valid_c5", {15'd0, out_valid}, 16'd0);
    check("t4_busy_c5",  {15'd0, busy},      16'd1);
    tick();
    check("t4_busy_c6", {15'd0, busy},     16'd0);
    check("t4_pop_c6",  {15'd0, fifo_pop}, 16'd0);
    check("t4_count",   word_count,        cnt(10));

    // 5: reset while one word is held and another is landing.
    push(4'd1); push(4'd2);
    enable = 1'b1; out_ready = 1'b0;
    #1;
    check("t5_pop_c0", {15'd0, fifo_pop}, 16'd1);
    tick();
    tick();
    check("t5_valid_pre", {15'd0, out_valid}, 16'd1);
    check("t5_data_pre",  {12'd0, out_data},  16'd3);
    reset = 1'b1;
    #1;
    check("t5_valid_rst", {15'd0, out_valid}, 16'd0);
    check("t5_pop_rst",   {15'd0, fifo_pop},  16'd0);
    check("t5_count_rst", word_count,         16'd0);
    check("t5_busy_rst",  {15'd0, busy},      16'd0);
    check("t5_data_rst",  {12'd0, out_data},  16'd0);
    tick();
    check("t5_pop_held",   {15'd0, fifo_pop},  16'd0);
    check("t5_valid_held", {15'd0, out_valid}, 16'd0);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("t5_pop_r0", {15'd0, fifo_pop}, 16'd1);
    tick();
    check("t5_valid_r1", {15'd0, out_valid}, 16'd0);
    tick();
    check("t5_valid_r2", {15'd0, out_valid}, 16'd1);
    check("t5_data_r2",  {12'd0, out_data},  16'd2);
    tick();
    check("t5_valid_r3", {15'd0, out_valid}, 16'd0);
    check("t5_count_r3", word_count,         cnt(1));

    // 6: 65536 more transfers; the counter wraps to 1 when enabled.
    for (int i = 0; i < 65536; i++) push(4'(i));
    rd_idx = 0;
    order_errs = 0;
    for (int c = 0; c < 70000 && rd_idx < 65536; c++) begin
      if (out_valid) begin
        if (out_data !== 4'(rd_idx)) order_errs++;
        rd_idx++;
      end
      tick();
    end
    check("t6_transfers", 16'(rd_idx == 65536), 16'd1);
    check("t6_order",     16'(order_errs),      16'd0);
    check("t6_count",     word_count,           cnt(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
